// File: rtl/disp_filter_pkg.sv
// Shared types, defaults and helpers for the disparity filtering pipeline.
// Default geometry matches the decimated stream: 240x180 pixels, 5-bit disparity.
// conf_decay() halves a confidence value so that filled pixels read as less trustworthy.
package disp_filter_pkg;

    localparam int DISP_BITS_DEF        = 5;
    localparam int DEC_FRAME_WIDTH_DEF  = 240;
    localparam int DEC_FRAME_HEIGHT_DEF = 180;
    localparam int FILL_LIMIT_DEF       = 8;

    typedef struct packed {
        logic [DISP_BITS_DEF-1:0] disp;
        logic [7:0]               conf;
    } disp_conf_t;

    function automatic logic [7:0] conf_decay(input logic [7:0] conf);
        return conf >> 1;
    endfunction

endpackage

// File: rtl/disp_hole_filler_if.sv
// Stream bundle for the hole filler: pixel input side plus tagged output side.
// Input: in_data {disp, conf}, in_valid, in_ready. Output: out_disp/conf/filled/eol/eof, out_valid, out_ready.
// master = upstream/downstream environment, slave = the hole filler itself.
interface disp_hole_filler_if #(
    parameter int disp_bits = disp_filter_pkg::DISP_BITS_DEF
);
    logic [disp_bits+7:0] in_data;
    logic                 in_valid;
    logic                 in_ready;
    logic [disp_bits-1:0] out_disp;
    logic [7:0]           out_conf;
    logic                 out_filled;
    logic                 out_eol;
    logic                 out_eof;
    logic                 out_valid;
    logic                 out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_disp, out_conf, out_filled, out_eol, out_eof, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_disp, out_conf, out_filled, out_eol, out_eof, out_valid
    );
endinterface

// File: rtl/frame_pos_counter.sv
// Column/row position tracker for a raster-scanned frame; advances once per accepted pixel.
// Latency: eol_o/eof_o are combinational on the current position; position updates next edge.
// Backpressure: none of its own; the owner only pulses advance_i on an accepted beat.
// Ports: clk, reset_n, advance_i, clear_i (sync, has priority), col_o, row_o, eol_o, eof_o.
module frame_pos_counter #(
    parameter  int width  = 240,
    parameter  int height = 180,
    localparam int COL_W  = (width  > 1) ? $clog2(width)  : 1,
    localparam int ROW_W  = (height > 1) ? $clog2(height) : 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             advance_i,
    input  logic             clear_i,
    output logic [COL_W-1:0] col_o,
    output logic [ROW_W-1:0] row_o,
    output logic             eol_o,
    output logic             eof_o
);
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;

    assign eol_o = (col_q == COL_W'(width - 1));
    assign eof_o = eol_o && (row_q == ROW_W'(height - 1));
    assign col_o = col_q;
    assign row_o = row_q;

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (clear_i) begin
            col_d = '0;
            row_d = '0;
        end else if (advance_i) begin
            if (eol_o) begin
                col_d = '0;
                row_d = eof_o ? '0 : row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end
endmodule

// File: rtl/disp_hole_filler.sv
// Replaces low-confidence disparities with the last confident one in the row, bounded run length.
// Latency: one cycle; an accepted beat is on the outputs after the next clock edge.
// Backpressure: in_ready = !frame_restart && (!out_valid || out_ready); outputs hold while stalled.
// Ports: clk, reset_n, conf_thresh, frame_restart, bus (slave: in_* pixel stream, out_* tagged stream).
module disp_hole_filler
    import disp_filter_pkg::*;
#(
    parameter int disp_bits        = DISP_BITS_DEF,
    parameter int dec_frame_width  = DEC_FRAME_WIDTH_DEF,
    parameter int dec_frame_height = DEC_FRAME_HEIGHT_DEF,
    parameter int fill_limit       = FILL_LIMIT_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [7:0]        conf_thresh,
    input  logic              frame_restart,
    disp_hole_filler_if.slave bus
);
    // Width never drops to zero so fill_limit=0 still elaborates (run_cnt < 0 is never true).
    localparam int RUN_W = (fill_limit > 0) ? $clog2(fill_limit + 1) : 1;
    localparam int COL_W = (dec_frame_width  > 1) ? $clog2(dec_frame_width)  : 1;
    localparam int ROW_W = (dec_frame_height > 1) ? $clog2(dec_frame_height) : 1;
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(fill_limit);

    logic [disp_bits-1:0] pix_disp;
    logic [7:0]           pix_conf;
    logic                 pix_good, fillable, in_rdy, accept;
    logic [COL_W-1:0]     pos_col;
    logic [ROW_W-1:0]     pos_row;
    logic                 pos_eol, pos_eof;
    logic                 unused_pos;

    logic [disp_bits-1:0] out_disp_q, out_disp_d, last_disp_q, last_disp_d;
    logic [7:0]           out_conf_q, out_conf_d, last_conf_q, last_conf_d;
    logic                 out_filled_q, out_filled_d, out_eol_q, out_eol_d;
    logic                 out_eof_q, out_eof_d, out_valid_q, out_valid_d;
    logic                 have_good_q, have_good_d;
    logic [RUN_W-1:0]     run_cnt_q, run_cnt_d;

    assign pix_disp = bus.in_data[disp_bits+7:8];
    assign pix_conf = bus.in_data[7:0];
    assign in_rdy   = !frame_restart && (!out_valid_q || bus.out_ready);
    assign accept   = bus.in_valid && in_rdy;
    assign pix_good = (pix_conf >= conf_thresh);
    assign fillable = have_good_q && (run_cnt_q < RUN_MAX);

    frame_pos_counter #(
        .width  (dec_frame_width),
        .height (dec_frame_height)
    ) u_pos (
        .clk       (clk),
        .reset_n   (reset_n),
        .advance_i (accept),
        .clear_i   (frame_restart),
        .col_o     (pos_col),
        .row_o     (pos_row),
        .eol_o     (pos_eol),
        .eof_o     (pos_eof)
    );

    // Only the markers matter here; the raw position is for later frame-writer stages.
    assign unused_pos = ^{pos_col, pos_row};

    always_comb begin
        out_disp_d   = out_disp_q;
        out_conf_d   = out_conf_q;
        out_filled_d = out_filled_q;
        out_eol_d    = out_eol_q;
        out_eof_d    = out_eof_q;
        out_valid_d  = out_valid_q;
        last_disp_d  = last_disp_q;
        last_conf_d  = last_conf_q;
        have_good_d  = have_good_q;
        run_cnt_d    = run_cnt_q;
        if (frame_restart) begin
            // Pending beat is dropped; the output data fields are don't-care while invalid.
            out_valid_d = 1'b0;
            have_good_d = 1'b0;
            run_cnt_d   = '0;
        end else if (accept) begin
            out_valid_d = 1'b1;
            out_eol_d   = pos_eol;
            out_eof_d   = pos_eof;
            if (pix_good) begin
                out_disp_d   = pix_disp;
                out_conf_d   = pix_conf;
                out_filled_d = 1'b0;
                last_disp_d  = pix_disp;
                last_conf_d  = pix_conf;
                have_good_d  = 1'b1;
                run_cnt_d    = '0;
            end else if (fillable) begin
                out_disp_d   = last_disp_q;
                out_conf_d   = conf_decay(last_conf_q);
                out_filled_d = 1'b1;
                run_cnt_d    = run_cnt_q + RUN_W'(1);
            end else begin
                out_disp_d   = '0;
                out_conf_d   = '0;
                out_filled_d = 1'b0;
            end
            // Fill history never carries across a row boundary.
            if (pos_eol) begin
                have_good_d = 1'b0;
                run_cnt_d   = '0;
            end
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_disp_q   <= '0;
            out_conf_q   <= '0;
            out_filled_q <= 1'b0;
            out_eol_q    <= 1'b0;
            out_eof_q    <= 1'b0;
            out_valid_q  <= 1'b0;
            last_disp_q  <= '0;
            last_conf_q  <= '0;
            have_good_q  <= 1'b0;
            run_cnt_q    <= '0;
        end else begin
            out_disp_q   <= out_disp_d;
            out_conf_q   <= out_conf_d;
            out_filled_q <= out_filled_d;
            out_eol_q    <= out_eol_d;
            out_eof_q    <= out_eof_d;
            out_valid_q  <= out_valid_d;
            last_disp_q  <= last_disp_d;
            last_conf_q  <= last_conf_d;
            have_good_q  <= have_good_d;
            run_cnt_q    <= run_cnt_d;
        end
    end

    assign bus.in_ready   = in_rdy;
    assign bus.out_disp   = out_disp_q;
    assign bus.out_conf   = out_conf_q;
    assign bus.out_filled = out_filled_q;
    assign bus.out_eol    = out_eol_q;
    assign bus.out_eof    = out_eof_q;
    assign bus.out_valid  = out_valid_q;
endmodule

// File: tb/tb_disp_hole_filler.sv
// Bench for disp_hole_filler: directed literal beats plus randomized traffic against a row-history model.
// Latency expectation: accepted beat visible one edge later; outputs compared every cycle.
// Backpressure: out_ready stalls and frame_restart pulses are exercised alongside in_ready checks.
module tb_disp_hole_filler;
    import disp_filter_pkg::*;

    localparam int DB   = 5;
    localparam int W    = 240;
    localparam int H    = 180;
    localparam int FILL = 2;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic [7:0] conf_thresh = 8'd100;
    logic       frame_restart = 1'b0;

    disp_hole_filler_if #(.disp_bits(DB)) bus();

    disp_hole_filler #(
        .disp_bits        (DB),
        .dec_frame_width  (W),
        .dec_frame_height (H),
        .fill_limit       (FILL)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .conf_thresh   (conf_thresh),
        .frame_restart (frame_restart),
        .bus           (bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int taken = 0, eol_cnt = 0, eof_cnt = 0, eof_at = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Position comes from the number of beats accepted since frame start; a bad pixel is
    // filled when a good pixel exists earlier in the same row within FILL columns.
    int         m_beat = 0;
    int         m_lg = -1;          // column of last good pixel in this row, -1 if none
    logic [4:0] m_ld = '0;
    logic [7:0] m_lc = '0;
    bit         e_valid = 1'b0;
    logic [4:0] e_disp = '0;
    logic [7:0] e_conf = '0;
    bit         e_filled = 1'b0, e_eol = 1'b0, e_eof = 1'b0;

    function automatic bit exp_in_ready();
        return !frame_restart && (!e_valid || bus.out_ready);
    endfunction

    always @(posedge clk or negedge reset_n) begin : model
        disp_conf_t px;
        int col, row;
        if (!reset_n) begin
            m_beat = 0; m_lg = -1; e_valid = 0;
            e_disp = '0; e_conf = '0; e_filled = 0; e_eol = 0; e_eof = 0;
        end else if (frame_restart) begin
            m_beat = 0; m_lg = -1; e_valid = 0;
        end else if (bus.in_valid && exp_in_ready()) begin
            px  = bus.in_data;
            col = m_beat % W;
            row = m_beat / W;
            if (col == 0) m_lg = -1;
            if (px.conf >= conf_thresh) begin
                e_disp = px.disp; e_conf = px.conf; e_filled = 0;
                m_lg = col; m_ld = px.disp; m_lc = px.conf;
            end else if (m_lg >= 0 && (col - m_lg) <= FILL) begin
                e_disp = m_ld; e_conf = m_lc / 2; e_filled = 1;
            end else begin
                e_disp = '0; e_conf = '0; e_filled = 0;
            end
            e_eol   = (col == W - 1);
            e_eof   = e_eol && (row == H - 1);
            m_beat  = (m_beat + 1) % (W * H);
            e_valid = 1;
        end else if (bus.out_ready) begin
            e_valid = 0;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            chk("in_ready", 32'(bus.in_ready), 32'(exp_in_ready()));
            chk("out_valid", 32'(bus.out_valid), 32'(e_valid));
            if (e_valid) begin
                chk("out_disp", 32'(bus.out_disp), 32'(e_disp));
                chk("out_conf", 32'(bus.out_conf), 32'(e_conf));
                chk("out_filled", 32'(bus.out_filled), 32'(e_filled));
                chk("out_eol", 32'(bus.out_eol), 32'(e_eol));
                chk("out_eof", 32'(bus.out_eof), 32'(e_eof));
            end
            if (bus.out_valid && bus.out_ready) begin
                taken++;
                if (bus.out_eol) eol_cnt++;
                if (bus.out_eof) begin
                    eof_cnt++;
                    eof_at = taken;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive_px(input logic [4:0] d, input logic [7:0] c);
        disp_conf_t px;
        px.disp = d;
        px.conf = c;
        bus.in_data = px;
    endtask

    // Called at posedge+2 with out_ready high; beat is accepted on the next edge.
    task automatic beat(input logic [4:0] d, input logic [7:0] c, input logic [4:0] ed,
                        input logic [7:0] ec, input logic ef, input logic eeol);
        bus.in_valid = 1'b1;
        drive_px(d, c);
        @(posedge clk);
        #1;
        chk("lit_valid", 32'(bus.out_valid), 32'd1);
        chk("lit_disp", 32'(bus.out_disp), 32'(ed));
        chk("lit_conf", 32'(bus.out_conf), 32'(ec));
        chk("lit_filled", 32'(bus.out_filled), 32'(ef));
        chk("lit_eol", 32'(bus.out_eol), 32'(eeol));
        #1;
    endtask

    task automatic pump(input int n);
        for (int i = 0; i < n; i++) begin
            bus.in_valid = 1'b1;
            drive_px(5'($urandom), 8'($urandom));
            @(posedge clk);
            #2;
        end
    endtask

    task automatic restart_pulse();
        bus.in_valid  = 1'b0;
        frame_restart = 1'b1;
        @(posedge clk);
        #2;
        frame_restart = 1'b0;
    endtask

    function automatic logic [7:0] rand_conf();
        int k;
        k = $urandom_range(0, 9);
        if (k < 3) return 8'd255;
        if (k < 5) return 8'd0;
        return 8'($urandom);
    endfunction

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;

        // Reset state
        #1 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_disp", 32'(bus.out_disp), 32'd0);
        chk("rst_conf", 32'(bus.out_conf), 32'd0);
        chk("rst_flags", 32'({bus.out_filled, bus.out_eol, bus.out_eof}), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        #1 reset_n = 1'b1;

        // Row 0: no good pixel yet, then fill within row, then run limit (FILL=2)
        conf_thresh = 8'd100;
        beat(5'd4, 8'd10, 5'd0, 8'd0, 1'b0, 1'b0);
        beat(5'd7, 8'd200, 5'd7, 8'd200, 1'b0, 1'b0);
        beat(5'd3, 8'd50, 5'd7, 8'd100, 1'b1, 1'b0);
        beat(5'd9, 8'd50, 5'd7, 8'd100, 1'b1, 1'b0);
        beat(5'd1, 8'd20, 5'd0, 8'd0, 1'b0, 1'b0);
        conf_thresh = 8'd60;
        beat(5'd6, 8'd80, 5'd6, 8'd80, 1'b0, 1'b0);
        beat(5'd2, 8'd5, 5'd6, 8'd40, 1'b1, 1'b0);
        beat(5'd2, 8'd5, 5'd6, 8'd40, 1'b1, 1'b0);
        beat(5'd2, 8'd5, 5'd0, 8'd0, 1'b0, 1'b0);
        conf_thresh = 8'd100;
        pump(W - 10);                                     // cols 9..238
        beat(5'd12, 8'd200, 5'd12, 8'd200, 1'b0, 1'b1);   // col 239
        beat(5'd5, 8'd10, 5'd0, 8'd0, 1'b0, 1'b0);        // row 1 col 0: no cross-row fill
        beat(5'd8, 8'd150, 5'd8, 8'd150, 1'b0, 1'b0);

        // Backpressure for 5 cycles, then frame_restart drops the stalled beat
        bus.out_ready = 1'b0;
        drive_px(5'd3, 8'd10);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
            chk("stall_valid", 32'(bus.out_valid), 32'd1);
            chk("stall_disp", 32'(bus.out_disp), 32'd8);
            #1;
        end
        frame_restart = 1'b1;
        #1;
        chk("rs_in_ready", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("rs_dropped", 32'(bus.out_valid), 32'd0);
        #1;
        frame_restart = 1'b0;
        bus.out_ready = 1'b1;
        beat(5'd3, 8'd10, 5'd0, 8'd0, 1'b0, 1'b0);

        // Full frame: markers counted at the output handshake
        restart_pulse();
        taken = 0; eol_cnt = 0; eof_cnt = 0; eof_at = 0;
        conf_thresh = 8'd128;
        for (int i = 0; i < W * H; i++) begin
            if (i % 5000 == 4999) conf_thresh = 8'($urandom);
            bus.in_valid = 1'b1;
            drive_px(5'($urandom), rand_conf());
            @(posedge clk);
            #2;
        end
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("frame_beats", 32'(taken), 32'(W * H));
        chk("frame_eol_cnt", 32'(eol_cnt), 32'(H));
        chk("frame_eof_cnt", 32'(eof_cnt), 32'd1);
        chk("frame_eof_at", 32'(eof_at), 32'(W * H));

        // Randomized traffic: stalls, threshold changes (incl. extremes), rare restarts
        for (int i = 0; i < 3000; i++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 9) < 7);
            frame_restart = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 15) == 0) begin
                case ($urandom_range(0, 2))
                    0:       conf_thresh = 8'd0;
                    1:       conf_thresh = 8'd255;
                    default: conf_thresh = 8'($urandom);
                endcase
            end
            drive_px(5'($urandom), rand_conf());
            @(posedge clk);
            #2;
        end
        frame_restart = 1'b0;
        bus.out_ready = 1'b1;

        // Async reset mid-row with a valid beat on the outputs (col 57)
        restart_pulse();
        conf_thresh = 8'd100;
        for (int i = 0; i < 58; i++) begin
            bus.in_valid = 1'b1;
            drive_px(5'd9, 8'd200);
            @(posedge clk);
            #2;
        end
        bus.in_valid = 1'b0;
        chk("pre_rst_valid", 32'(bus.out_valid), 32'd1);
        #1 reset_n = 1'b0;
        #1;
        chk("arst_valid", 32'(bus.out_valid), 32'd0);
        chk("arst_disp", 32'(bus.out_disp), 32'd0);
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        beat(5'd3, 8'd10, 5'd0, 8'd0, 1'b0, 1'b0);        // no fill from pre-reset row
        pump(W - 2);
        beat(5'd1, 8'd200, 5'd1, 8'd200, 1'b0, 1'b1);     // 240th beat after reset is eol
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
